// File: rtl/reg_file.sv
// Single-port register file: one shared address, flip-flop storage, registered read port.
// Concurrent WrEn and RdEn is treated as a no-op so RdData and storage both hold.
module reg_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  wr_ok;
    logic                  rd_ok;

    // Both enables at once cancel each other.
    assign wr_ok = WrEn & ~RdEn;
    assign rd_ok = RdEn & ~WrEn;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (wr_ok && (Address == ADDR_WIDTH'(gi))) begin
                    mem_q[gi] <= WrData;
                end
            end
        end
    endgenerate

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_ok) begin
            rd_data_d = mem_q[Address];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign RdData = rd_data_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized checks of reg_file against hand-computed values and a reference array.
`timescale 1ns/1ps
module tb_reg_file;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic [DW-1:0] RdData;

    int n_cmp;
    int n_err;

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .WrEn    (WrEn),
        .RdEn    (RdEn),
        .Address (Address),
        .WrData  (WrData),
        .RdData  (RdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, let the edge take them, then return to idle #1 after the edge.
    task automatic op(input logic r, input logic w, input logic rd,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst     = r;
        WrEn    = w;
        RdEn    = rd;
        Address = a;
        WrData  = d;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        WrEn = 1'b0;
        RdEn = 1'b0;
        $display("t=%0t op rst=%0b wr=%0b rd=%0b addr=%0d wdata=%h -> RdData=%h",
                 $time, r, w, rd, a, d, RdData);
    endtask

    task automatic test_reset();
        op(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
        op(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
        n_cmp++;
        if (RdData !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_rddata: got %h expected 0000", RdData);
        end
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b0, 1'b1, AW'(i), 16'h0000);
            n_cmp++;
            if (RdData !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_read addr %0d: got %h expected 0000", i, RdData);
            end
        end
    endtask

    task automatic test_write_read();
        op(1'b0, 1'b1, 1'b0, 4'd3, 16'hA5A5);
        n_cmp++;
        if (RdData !== 16'h0000) begin
            n_err++;
            $display("FAIL write_keeps_rddata: got %h expected 0000", RdData);
        end
        op(1'b0, 1'b1, 1'b0, 4'd15, 16'h1234);
        op(1'b0, 1'b0, 1'b1, 4'd3, 16'h0000);
        n_cmp++;
        if (RdData !== 16'hA5A5) begin
            n_err++;
            $display("FAIL read_addr3: got %h expected a5a5", RdData);
        end
        op(1'b0, 1'b0, 1'b1, 4'd15, 16'h0000);
        n_cmp++;
        if (RdData !== 16'h1234) begin
            n_err++;
            $display("FAIL read_addr15: got %h expected 1234", RdData);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 15) continue;
            op(1'b0, 1'b0, 1'b1, AW'(i), 16'hFFFF);
            n_cmp++;
            if (RdData !== 16'h0000) begin
                n_err++;
                $display("FAIL read_other addr %0d: got %h expected 0000", i, RdData);
            end
        end
    endtask

    task automatic test_overwrite_hold();
        op(1'b0, 1'b1, 1'b0, 4'd3, 16'h00FF);
        op(1'b0, 1'b0, 1'b1, 4'd3, 16'h0000);
        n_cmp++;
        if (RdData !== 16'h00FF) begin
            n_err++;
            $display("FAIL overwrite_addr3: got %h expected 00ff", RdData);
        end
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 1'b0, 1'b0, AW'(i + 7), 16'hCAFE);
            n_cmp++;
            if (RdData !== 16'h00FF) begin
                n_err++;
                $display("FAIL idle_hold cycle %0d: got %h expected 00ff", i, RdData);
            end
        end
    endtask

    task automatic test_illegal();
        op(1'b0, 1'b1, 1'b1, 4'd5, 16'hBEEF);
        n_cmp++;
        if (RdData !== 16'h00FF) begin
            n_err++;
            $display("FAIL illegal_hold: got %h expected 00ff", RdData);
        end
        op(1'b0, 1'b0, 1'b1, 4'd5, 16'h0000);
        n_cmp++;
        if (RdData !== 16'h0000) begin
            n_err++;
            $display("FAIL illegal_no_write addr5: got %h expected 0000", RdData);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 1'b0, AW'(i), DW'(i * 16'h1111));
        end
        op(1'b0, 1'b0, 1'b1, 4'd7, 16'h0000);
        n_cmp++;
        if (RdData !== 16'h7777) begin
            n_err++;
            $display("FAIL fill_read addr7: got %h expected 7777", RdData);
        end
        op(1'b1, 1'b1, 1'b0, 4'd2, 16'hDEAD);
        n_cmp++;
        if (RdData !== 16'h0000) begin
            n_err++;
            $display("FAIL midreset_rddata: got %h expected 0000", RdData);
        end
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b0, 1'b1, AW'(i), 16'h0000);
            n_cmp++;
            if (RdData !== 16'h0000) begin
                n_err++;
                $display("FAIL midreset_read addr %0d: got %h expected 0000", i, RdData);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] model [16];
        logic [DW-1:0] rd_model;
        logic          prev_wr;
        logic [AW-1:0] prev_addr;
        for (int i = 0; i < 16; i++) model[i] = '0;
        rd_model  = RdData === 16'h0000 ? 16'h0000 : 16'hxxxx;
        prev_wr   = 1'b0;
        prev_addr = '0;
        for (int n = 0; n < 1000; n++) begin
            logic          w;
            logic          r;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            kind;
            kind = $urandom_range(0, 9);
            a    = AW'($urandom_range(0, 15));
            d    = DW'($urandom);
            w    = (kind < 4) || (kind == 9);
            r    = (kind >= 4 && kind < 8) || (kind == 9);
            if (prev_wr && $urandom_range(0, 1) == 1) begin
                w = 1'b0;
                r = 1'b1;
                a = prev_addr;
            end
            op(1'b0, w, r, a, d);
            if (w && !r) model[a] = d;
            if (r && !w) rd_model = model[a];
            n_cmp++;
            if (RdData !== rd_model) begin
                n_err++;
                $display("FAIL random op %0d wr=%0b rd=%0b addr=%0d: got %h expected %h",
                         n, w, r, a, RdData, rd_model);
            end
            prev_wr   = w && !r;
            prev_addr = a;
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b0;
        WrEn    = 1'b0;
        RdEn    = 1'b0;
        Address = '0;
        WrData  = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_overwrite_hold();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Synchronous single-port register-file storage block for the datapath. It holds results produced by the ALU and returns them on request. One address bus is shared by the write and read operations, so at most one access happens per clock cycle. All state changes on the rising clock edge.

## Interface
Parameters:
- DATA_WIDTH, 16: width of each storage word and of WrData/RdData.
- ADDR_WIDTH, 4: width of Address; depth = 2**ADDR_WIDTH (16 words).

Ports:
- clk  input  1  system clock; all logic rising-edge triggered.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- WrEn  input  1  write enable.
- RdEn  input  1  read enable.
- Address  input  ADDR_WIDTH  word address shared by read and write.
- WrData  input  DATA_WIDTH  data to store.
- RdData  output  DATA_WIDTH  registered read data.

## Operation
- Storage is an array of 2**ADDR_WIDTH words of DATA_WIDTH bits, implemented as flip-flops.
- Reset (rst=1 at a rising edge):
  - Clears every storage word to 0.
  - Clears RdData to 0.
  - Has priority over WrEn and RdEn. No write or read occurs in that cycle.
- Write (WrEn=1, RdEn=0): the word at Address is loaded with WrData at the rising edge. RdData is unchanged.
- Read (RdEn=1, WrEn=0): RdData is loaded with the word at Address at the rising edge. Storage is unchanged.
- WrEn=1 and RdEn=1 together are an illegal combination:
  - No write occurs.
  - No read occurs.
  - RdData holds its value.
- Idle (WrEn=0, RdEn=0): storage and RdData hold.
- Every Address value is valid (full decode), so there is no out-of-range case.
- WrData is ignored unless a write occurs.
- Storage contents persist indefinitely until overwritten or reset.

## Timing
- Write latency: data is stored at the edge where WrEn=1 is sampled. A read issued in the following cycle returns the new value.
- Read latency: 1 cycle. RdData is valid after the edge that samples RdEn=1 and stays stable until the next read or reset.
- Back-to-back reads to different addresses update RdData every cycle.
- There is no combinational path from any input to RdData.
- Reset asserted in the middle of a sequence takes effect at the next edge. After reset, every read returns 0 until the address is written.
- Inputs must be stable around the rising edge. They are sampled only at the edge.
- Asynchronous behaviour of rst is not supported. A pulse that does not span a rising edge has no effect.

## Test plan
- Reset: hold rst=1 for 2 cycles, then read all 16 addresses -> RdData=0x0000 for each, one cycle after each RdEn.
- Write/read: write 0xA5A5 to addr 3 and 0x1234 to addr 15, then read addr 3 and addr 15 -> RdData=0xA5A5, then 0x1234. Other addresses still read 0.
- Overwrite and hold:
  - Write 0x00FF to addr 3, then read addr 3 -> 0x00FF.
  - Idle 3 cycles -> RdData stays 0x00FF.
- Illegal simultaneous enables: WrEn=1, RdEn=1, addr 5, WrData=0xBEEF -> RdData unchanged. A subsequent read of addr 5 returns its prior value (0).
- Reset mid-operation:
  - Fill all addresses with the pattern addr*0x1111, then assert rst for one cycle with WrEn=1 -> all reads return 0 and the write is dropped.
- Random: 1000 random write/read/idle operations checked against a reference array model. The model must include back-to-back write-then-read to the same address.
